bias_scheduler: RTL and testbench
=================================

# bias_scheduler

Per-layer bias sequencer for the bias stage at the bottom of the systolic array. It streams one 16-bit signed bias scalar per column from the unified buffer into a shadow bank. It commits that bank to the per-column bias adders only at a layer boundary, then counts valid rows per column so the bias values never change while rows of the current layer are still draining. It lets the next layer's biases load while the current layer runs.

## Interface
Parameters:
- N_COLS, 2: number of systolic columns / bias children driven.
- ROW_W, 8: width of the per-layer row count.

Ports:
- clk  input  1  clock.
- rst  input  1  reset: asynchronous, active-high.
- ub_bias_valid_in  input  1  bias beat valid from unified buffer.
- ub_bias_data_in  input  16  signed bias scalar beat; column 0 first.
- ub_bias_ready_out  output  1  shadow bank can accept a beat.
- commit_in  input  1  one-cycle request: shadow becomes next layer's bias.
- layer_rows_in  input  ROW_W  rows per column for the committed layer; sampled with commit_in.
- col_valid_in  input  N_COLS  per-column systolic output valid (the same signals that feed each bias child).
- bias_scalar_out  output  16*N_COLS  active bias; column c at bits [16c+15:16c].
- busy_out  output  1  a layer is active.
- layer_done_out  output  1  one-cycle pulse: all columns received layer_rows_in rows.
- err_out  output  1  sticky overrun flag (see Configuration).

## Operation
- Shadow loader FSM: EMPTY → FILLING → FULL.
  - ub_bias_ready_out = (loader != FULL), combinational from state.
  - Each accepted beat (valid & ready) writes shadow[idx] and increments idx.
  - Accepting the beat at idx = N_COLS-1 moves the loader to FULL and resets idx to 0.
- Commit request: commit_in sets pend and captures layer_rows_in into rows_pend.
  - A second commit_in while pend is set overwrites rows_pend.
- Active FSM: IDLE ↔ RUN.
  - Commit fires when pend & loader == FULL & active == IDLE.
  - On that edge: active bank ← shadow; each per-column counter ← 0; target ← rows_pend; pend ← 0; loader ← EMPTY; active ← RUN. If rows_pend = 0, active stays IDLE and layer_done_out pulses instead.
- In RUN, col_valid_in[c] increments cnt[c] while cnt[c] < target.
  - When every cnt[c] == target, active → IDLE and layer_done_out pulses for one cycle.
- Overrun: col_valid_in[c] while IDLE, or while cnt[c] == target.
  - The valid is not counted and the bias is unchanged.
  - Sets err_out when ERR_EN is compiled in.
- bias_scalar_out holds the last committed values indefinitely, including while IDLE.
- The loader may refill the shadow during RUN. It does not disturb the active bank.
- Values are passed through unchanged: 16-bit two's complement, no arithmetic in this block.

## Timing
- Reset values:
  - bias_scalar_out = 0, busy_out = 0, layer_done_out = 0, err_out = 0.
  - Loader EMPTY (ub_bias_ready_out = 1), idx = 0, pend = 0, counters = 0.
- Reset mid-layer or mid-load aborts everything; partial shadow contents are discarded.
- Beat-to-FULL: ub_bias_ready_out drops the cycle after the final beat is accepted.
- Commit latency: new bias_scalar_out and busy_out = 1 appear the cycle after the edge where the commit condition holds.
  - If commit_in arrives with the loader already FULL and active IDLE: bias visible 2 cycles after commit_in (pend registers, then commit).
- The bias must be stable on every cycle col_valid_in is high. The first counted row may arrive the cycle bias_scalar_out updates.
- Completion: layer_done_out and busy_out = 0 are asserted the cycle after the last counted valid is sampled.
  - A pending commit fires on that same edge at the earliest. New bias therefore appears ≥2 cycles after the last row.
- Simultaneous events:
  - commit_in in the same cycle as the final shadow beat: pend is set; commit fires on the following edge if active is IDLE.
  - commit_in during RUN is held pending, not dropped.

## Configuration
- BIAS_SCHED_ERR_EN defined: overrun detection is implemented. err_out is set on any overrun valid and stays set until rst.
- Not defined: detection logic is omitted and err_out is tied 0. Overrun valids are still ignored for counting.

## Test plan
- Reset: assert rst mid-RUN → next cycle all outputs 0, ub_bias_ready_out = 1, prior bias is not restored after deassert.
- Basic layer (N_COLS=2):
  - Load 0x0100, 0xFF80, then commit_in with rows = 3 → bias_scalar_out = {0xFF80, 0x0100}, busy_out = 1.
  - 3 valids per column → layer_done_out pulses once, busy_out = 0.
- Double buffer: during RUN, load 0x0020, 0x0030 and pulse commit_in → bias unchanged until the last row; new bias appears exactly 2 cycles after the last counted valid.
- Backpressure: hold ub_bias_valid_in high through 4 beats with the shadow uncommitted → only 2 accepted, ub_bias_ready_out = 0 from the cycle after the 2nd beat.
- Skewed columns (rows = 2): column 0 finishes 3 cycles before column 1 → layer_done_out only after column 1's 2nd valid.
- Zero rows and overrun:
  - commit rows = 0 → layer_done_out next cycle, busy_out stays 0.
  - A valid in IDLE → err_out = 1 with BIAS_SCHED_ERR_EN, 0 without it.

Source files
------------

// File: rtl/bias_scheduler.sv
// bias_scheduler
//   Per-layer bias sequencer for the bias stage below the systolic array.
//   Bias scalars stream from the unified buffer into a shadow bank (column 0
//   first). A commit copies the shadow into the active bank. The commit waits
//   until the shadow is full and no layer is running. Valid rows are counted
//   per column so the active bias only changes between layers. The next
//   layer's biases may load while the current layer runs.
//
//   Optional feature macro: BIAS_SCHED_ERR_EN
//     defined   -> err_out is a sticky overrun flag (valid while idle or
//                  after a column already reached its target).
//     undefined -> err_out is tied low. Overrun valids are still not counted.
//
// Ports
//   clk, rst             clock; asynchronous active-high reset
//   ub_bias_valid_in     bias beat valid from unified buffer
//   ub_bias_data_in      16-bit signed bias beat
//   ub_bias_ready_out    shadow bank can accept a beat
//   commit_in            one-cycle commit request
//   layer_rows_in        rows per column for the layer, sampled with commit_in
//   col_valid_in         per-column systolic output valid
//   bias_scalar_out      active bias, column c at [16c+15:16c]
//   busy_out             a layer is active
//   layer_done_out       one-cycle pulse when all columns reached their target
//   err_out              sticky overrun flag
module bias_scheduler #(
  parameter int unsigned N_COLS = 2,
  parameter int unsigned ROW_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ub_bias_valid_in,
  input  logic [15:0]          ub_bias_data_in,
  output logic                 ub_bias_ready_out,
  input  logic                 commit_in,
  input  logic [ROW_W-1:0]     layer_rows_in,
  input  logic [N_COLS-1:0]    col_valid_in,
  output logic [16*N_COLS-1:0] bias_scalar_out,
  output logic                 busy_out,
  output logic                 layer_done_out,
  output logic                 err_out
);

  localparam int unsigned IDX_W = (N_COLS > 1) ? $clog2(N_COLS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_COLS - 1);

  typedef enum logic [1:0] {LD_EMPTY, LD_FILLING, LD_FULL} loader_t;
  typedef enum logic {ACT_IDLE, ACT_RUN} active_t;

  loader_t              loader;
  active_t              active;
  logic [IDX_W-1:0]     idx;
  logic [15:0]          shadow [N_COLS];
  logic                 pend;
  logic [ROW_W-1:0]     rows_pend;
  logic [ROW_W-1:0]     target;
  logic [ROW_W-1:0]     cnt     [N_COLS];
  logic [ROW_W-1:0]     cnt_nxt [N_COLS];
  logic [16*N_COLS-1:0] bias_q;
  logic                 layer_done;
  logic                 beat;
  logic                 fire;
  logic                 all_hit;

  assign ub_bias_ready_out = (loader != LD_FULL);
  assign beat              = ub_bias_valid_in && ub_bias_ready_out;
  assign fire              = pend && (loader == LD_FULL) && (active == ACT_IDLE);

  assign bias_scalar_out = bias_q;
  assign busy_out        = (active == ACT_RUN);
  assign layer_done_out  = layer_done;

  // Completion is judged on the post-increment counts so that done and the
  // drop of busy appear the cycle right after the last counted valid.
  always_comb begin
    all_hit = 1'b1;
    for (int unsigned c = 0; c < N_COLS; c++) begin
      cnt_nxt[c] = cnt[c];
      if (col_valid_in[c] && (active == ACT_RUN) && (cnt[c] < target))
        cnt_nxt[c] = cnt[c] + ROW_W'(1);
      if (cnt_nxt[c] != target)
        all_hit = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loader     <= LD_EMPTY;
      active     <= ACT_IDLE;
      idx        <= '0;
      pend       <= 1'b0;
      rows_pend  <= '0;
      target     <= '0;
      bias_q     <= '0;
      layer_done <= 1'b0;
      for (int unsigned c = 0; c < N_COLS; c++) begin
        shadow[c] <= '0;
        cnt[c]    <= '0;
      end
    end else begin
      layer_done <= 1'b0;

      if (beat) begin
        shadow[idx] <= ub_bias_data_in;
        if (idx == IDX_LAST) begin
          idx    <= '0;
          loader <= LD_FULL;
        end else begin
          idx    <= idx + IDX_W'(1);
          loader <= LD_FILLING;
        end
      end

      // A fresh request always wins over the clear from a firing commit, so a
      // commit_in arriving on the firing edge is queued rather than lost.
      if (commit_in) begin
        pend      <= 1'b1;
        rows_pend <= layer_rows_in;
      end else if (fire) begin
        pend <= 1'b0;
      end

      // fire implies the loader is FULL, so no beat can collide with the
      // loader reset below.
      if (fire) begin
        loader <= LD_EMPTY;
        idx    <= '0;
        target <= rows_pend;
        for (int unsigned c = 0; c < N_COLS; c++) begin
          bias_q[16*c +: 16] <= shadow[c];
          cnt[c]             <= '0;
        end
        if (rows_pend == '0)
          layer_done <= 1'b1;
        else
          active <= ACT_RUN;
      end else if (active == ACT_RUN) begin
        for (int unsigned c = 0; c < N_COLS; c++)
          cnt[c] <= cnt_nxt[c];
        if (all_hit) begin
          active     <= ACT_IDLE;
          layer_done <= 1'b1;
        end
      end
    end
  end

`ifdef BIAS_SCHED_ERR_EN
  logic overrun;
  logic err_q;

  always_comb begin
    overrun = 1'b0;
    for (int unsigned c = 0; c < N_COLS; c++)
      if (col_valid_in[c] && !((active == ACT_RUN) && (cnt[c] < target)))
        overrun = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_q <= 1'b0;
    else if (overrun)
      err_q <= 1'b1;
  end

  assign err_out = err_q;
`else
  assign err_out = 1'b0;
`endif

endmodule

// File: tb/tb_bias_scheduler.sv
// Directed testbench for bias_scheduler (N_COLS=2, ROW_W=8).
// Inputs are driven 1ns after each rising edge and outputs are sampled at
// the same point, so every check sees the state registered by that edge.
module tb_bias_scheduler;

  logic        clk;
  logic        rst;
  logic        ub_bias_valid_in;
  logic [15:0] ub_bias_data_in;
  logic        ub_bias_ready_out;
  logic        commit_in;
  logic [7:0]  layer_rows_in;
  logic [1:0]  col_valid_in;
  logic [31:0] bias_scalar_out;
  logic        busy_out;
  logic        layer_done_out;
  logic        err_out;

  int n_checks = 0;
  int n_pass   = 0;

`ifdef BIAS_SCHED_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  bias_scheduler #(.N_COLS(2), .ROW_W(8)) dut (
    .clk               (clk),
    .rst               (rst),
    .ub_bias_valid_in  (ub_bias_valid_in),
    .ub_bias_data_in   (ub_bias_data_in),
    .ub_bias_ready_out (ub_bias_ready_out),
    .commit_in         (commit_in),
    .layer_rows_in     (layer_rows_in),
    .col_valid_in      (col_valid_in),
    .bias_scalar_out   (bias_scalar_out),
    .busy_out          (busy_out),
    .layer_done_out    (layer_done_out),
    .err_out           (err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic beat(input logic [15:0] d);
    ub_bias_valid_in = 1'b1;
    ub_bias_data_in  = d;
    step();
    ub_bias_valid_in = 1'b0;
  endtask

  task automatic commit(input logic [7:0] rows);
    commit_in     = 1'b1;
    layer_rows_in = rows;
    step();
    commit_in     = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    ub_bias_valid_in = 1'b0;
    ub_bias_data_in  = '0;
    commit_in        = 1'b0;
    layer_rows_in    = '0;
    col_valid_in     = '0;
    step(3);
    rst = 1'b0;
    step();

    // Reset state
    check("rst_bias",  bias_scalar_out, 32'h0);
    check("rst_busy",  {31'b0, busy_out}, 32'h0);
    check("rst_done",  {31'b0, layer_done_out}, 32'h0);
    check("rst_err",   {31'b0, err_out}, 32'h0);
    check("rst_ready", {31'b0, ub_bias_ready_out}, 32'h1);

    // Basic layer: biases 0x0100, 0xFF80, rows = 3
    beat(16'h0100);
    check("basic_ready_mid", {31'b0, ub_bias_ready_out}, 32'h1);
    beat(16'hFF80);
    check("basic_ready_full", {31'b0, ub_bias_ready_out}, 32'h0);
    commit(8'd3);
    check("basic_bias_pend", bias_scalar_out, 32'h0);
    step();
    check("basic_bias", bias_scalar_out, 32'hFF80_0100);
    check("basic_busy", {31'b0, busy_out}, 32'h1);
    check("basic_ready_empty", {31'b0, ub_bias_ready_out}, 32'h1);
    col_valid_in = 2'b11;
    step(2);
    check("basic_done_early", {31'b0, layer_done_out}, 32'h0);
    check("basic_busy_mid", {31'b0, busy_out}, 32'h1);
    step();
    col_valid_in = 2'b00;
    check("basic_done", {31'b0, layer_done_out}, 32'h1);
    check("basic_busy_end", {31'b0, busy_out}, 32'h0);
    step();
    check("basic_done_pulse", {31'b0, layer_done_out}, 32'h0);
    check("basic_bias_hold", bias_scalar_out, 32'hFF80_0100);

    // Double buffer: start layer A (rows 2), load and commit B during RUN
    beat(16'h1111);
    beat(16'h2222);
    commit(8'd2);
    step();
    check("dbuf_biasA", bias_scalar_out, 32'h2222_1111);
    beat(16'h0020);
    beat(16'h0030);
    commit(8'd2);
    check("dbuf_biasA_hold", bias_scalar_out, 32'h2222_1111);
    check("dbuf_busyA", {31'b0, busy_out}, 32'h1);
    col_valid_in = 2'b11;
    step();
    check("dbuf_biasA_row1", bias_scalar_out, 32'h2222_1111);
    step();
    col_valid_in = 2'b00;
    check("dbuf_doneA", {31'b0, layer_done_out}, 32'h1);
    check("dbuf_biasA_last", bias_scalar_out, 32'h2222_1111);
    step();
    check("dbuf_biasB", bias_scalar_out, 32'h0030_0020);
    check("dbuf_busyB", {31'b0, busy_out}, 32'h1);

    // Skewed columns on layer B (rows 2): col 0 ends 3 cycles before col 1
    col_valid_in = 2'b11;
    step();
    col_valid_in = 2'b01;
    step();
    col_valid_in = 2'b00;
    step();
    check("skew_done_0", {31'b0, layer_done_out}, 32'h0);
    step();
    check("skew_busy", {31'b0, busy_out}, 32'h1);
    col_valid_in = 2'b10;
    step();
    col_valid_in = 2'b00;
    check("skew_done", {31'b0, layer_done_out}, 32'h1);
    check("skew_busy_end", {31'b0, busy_out}, 32'h0);
    check("skew_err_clean", {31'b0, err_out}, 32'h0);

    // Backpressure: 4 beats offered, only 2 accepted
    ub_bias_valid_in = 1'b1;
    ub_bias_data_in  = 16'hAAAA;
    step();
    check("bp_ready_1", {31'b0, ub_bias_ready_out}, 32'h1);
    ub_bias_data_in  = 16'hBBBB;
    step();
    check("bp_ready_2", {31'b0, ub_bias_ready_out}, 32'h0);
    ub_bias_data_in  = 16'hCCCC;
    step();
    ub_bias_data_in  = 16'hDDDD;
    step();
    check("bp_ready_4", {31'b0, ub_bias_ready_out}, 32'h0);
    ub_bias_valid_in = 1'b0;

    // Zero rows: done next cycle after commit fires, busy never rises
    commit(8'd0);
    step();
    check("zero_done", {31'b0, layer_done_out}, 32'h1);
    check("zero_busy", {31'b0, busy_out}, 32'h0);
    check("zero_bias", bias_scalar_out, 32'hBBBB_AAAA);
    step();
    check("zero_done_pulse", {31'b0, layer_done_out}, 32'h0);
    check("zero_busy_after", {31'b0, busy_out}, 32'h0);

    // Overrun while idle
    col_valid_in = 2'b11;
    step();
    col_valid_in = 2'b00;
    check("ovr_err", {31'b0, err_out}, {31'b0, ERR_EXP});
    check("ovr_bias", bias_scalar_out, 32'hBBBB_AAAA);
    step(2);
    check("ovr_err_sticky", {31'b0, err_out}, {31'b0, ERR_EXP});

    // Reset mid-RUN with a partial shadow load
    beat(16'h1234);
    beat(16'h5678);
    commit(8'd5);
    step();
    check("mrst_busy_pre", {31'b0, busy_out}, 32'h1);
    col_valid_in = 2'b11;
    step();
    col_valid_in = 2'b00;
    beat(16'h7777);
    rst = 1'b1;
    step();
    check("mrst_bias", bias_scalar_out, 32'h0);
    check("mrst_busy", {31'b0, busy_out}, 32'h0);
    check("mrst_err", {31'b0, err_out}, 32'h0);
    check("mrst_ready", {31'b0, ub_bias_ready_out}, 32'h1);
    rst = 1'b0;
    step(2);
    check("mrst_bias_after", bias_scalar_out, 32'h0);
    check("mrst_done_after", {31'b0, layer_done_out}, 32'h0);
    // Partial shadow discarded: one beat now must not fill the bank
    beat(16'h4444);
    check("mrst_partial", {31'b0, ub_bias_ready_out}, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
